// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a forwarding tap for the hazard unit.
module ex_mem_pipe_reg #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [XLEN-1:0]   AluResult,
  input  logic [XLEN-1:0]   Datain,
  input  logic [REG_AW-1:0] Rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic              MemWrite_Out,
  output logic              MemRead_Out,
  output logic [XLEN-1:0]   AluOut,
  output logic [XLEN-1:0]   DataOut,
  output logic [REG_AW-1:0] Rd_out,
  output logic              fwd_en
);

  localparam int PW = 4 + 2 * XLEN + REG_AW;

  logic [PW-1:0]     in_pl;
  logic [PW-1:0]     main_q;
  logic [PW-1:0]     main_d;
  logic              accept;
  logic              drain;
  logic              rw_m;
  logic              mtr_m;
  logic              mw_m;
  logic              mr_m;
  logic [XLEN-1:0]   alu_m;
  logic [XLEN-1:0]   din_m;
  logic [REG_AW-1:0] rd_m;

  assign in_pl  = {RegWrite, MemtoReg, MemWrite, MemRead, AluResult, Datain, Rd_in};
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
      state_e        state_q;
      state_e        state_d;
      logic [PW-1:0] skid_q;
      logic [PW-1:0] skid_d;

      // Both handshake outputs decode the state register only, so in_ready never
      // depends combinationally on out_ready.
      assign in_ready  = (state_q != TWO);
      assign out_valid = (state_q != EMPTY);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                state_d = ONE;
                main_d  = in_pl;
              end
            end
            ONE: begin
              if (accept && !drain) begin
                state_d = TWO;
                skid_d  = in_pl;
              end else if (accept && drain) begin
                main_d = in_pl;
              end else if (drain) begin
                state_d = EMPTY;
              end
            end
            TWO: begin
              if (drain) begin
                state_d = ONE;
                main_d  = skid_q;
              end
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end else begin : g_noskid
      logic valid_q;
      logic valid_d;

      assign in_ready  = !valid_q | out_ready;
      assign out_valid = valid_q;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (accept) begin
          valid_d = 1'b1;
          main_d  = in_pl;
        end else if (drain) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end
    end
  endgenerate

  assign {rw_m, mtr_m, mw_m, mr_m, alu_m, din_m, rd_m} = main_q;

  // Side-effecting controls are masked during bubbles; data fields just hold.
  assign RegWrite_Out = out_valid & rw_m;
  assign MemtoReg_Out = mtr_m;
  assign MemWrite_Out = out_valid & mw_m;
  assign MemRead_Out  = out_valid & mr_m;
  assign AluOut       = alu_m;
  assign DataOut      = din_m;
  assign Rd_out       = rd_m;
  assign fwd_en       = out_valid & rw_m & (rd_m != '0);

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX/MEM pipeline register for the five-stage core; successor to the fixed 64-bit EX_MEM register.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for MEM-stage stalls, synchronous flush for bubble insertion, and a forwarding tap for the hazard unit.
- Sits between the EX-stage ALU and the data-memory/MEM stage.

Parameters:
- XLEN, 64: width of AluResult and Datain paths.
- REG_AW, 5: register-address width of Rd.
- SKID, 1: 1 = 2-entry skid buffer (main + skid); 0 = single entry with combinational ready pass-through.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  in  1  synchronous flush: discard all held entries.
- in_valid  in  1  EX stage presents a valid instruction.
- in_ready  out  1  register can accept this cycle.
- RegWrite, MemtoReg, MemWrite, MemRead  in  1 each  control bits from EX.
- AluResult  in  XLEN  ALU result or memory address.
- Datain  in  XLEN  store data (rs2).
- Rd_in  in  REG_AW  destination register.
- out_valid  out  1  MEM stage sees a valid entry.
- out_ready  in  1  MEM stage consumes the entry this cycle.
- RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_Out  out  1 each  registered control bits.
- AluOut, DataOut  out  XLEN  registered data.
- Rd_out  out  REG_AW  registered destination.
- fwd_en  out  1  out_valid & RegWrite_Out & (Rd_out != 0).

Behaviour:
- Handshake terms: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (reset=0 at an edge):
  - out_valid=0; all data outputs zero; skid entry empty.
  - in_ready=1 from the first cycle after the reset edge.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N. Strict FIFO order; no entry is dropped or duplicated except by flush or reset.
- Bubble gating: while out_valid=0, RegWrite_Out, MemWrite_Out, MemRead_Out and fwd_en are forced 0. Data outputs hold their last value.
- SKID=1 state machine (state fully determined by occupancy):
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> TWO (new entry goes to skid). accept & drain -> ONE (new entry loads main). drain & !accept -> EMPTY.
  - TWO: drain -> ONE (skid moves into main). No accept is possible.
  - in_ready = !(state==TWO); it is a registered signal with no combinational path from out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - accept loads main; drain without accept clears out_valid.
- flush=1 at an edge:
  - Next state EMPTY and out_valid=0. Any same-cycle accept is discarded.
  - flush overrides drain and accept.
  - reset=0 overrides flush.
- Stall: out_ready=0 holds every output bit-stable until drain.
- Rd_in=0 with RegWrite=1 is passed through unchanged; fwd_en stays 0.
- Width rule: data is stored and forwarded verbatim at XLEN; no extension or truncation.

Test Plan:
- Reset then pass-through: reset=0 for 2 cycles, release; apply one entry (AluResult=64'h0000_0000_DEAD_BEEF, Datain=64'h1234, Rd_in=5'd7, RegWrite=1, out_ready=1) -> next cycle out_valid=1, AluOut=64'h0000_0000_DEAD_BEEF, Rd_out=7, fwd_en=1; the cycle after, out_valid=0.
- Skid fill (SKID=1): out_ready=0, send A (Rd=1) then B (Rd=2) -> in_ready=0 after the second accept; Rd_out holds 1. Raise out_ready -> Rd_out=1, then 2, then out_valid=0.
- Flush mid-stall: state TWO; assert flush with in_valid=1 (Rd=3) -> next cycle out_valid=0, in_ready=1, RegWrite_Out=0, and Rd=3 never appears on the outputs.
- Back-to-back streaming: in_valid=1 and out_ready=1 continuously with Rd=1..8 -> out_valid stays 1 from the second cycle, Rd_out steps 1..8 with no gaps, in_ready is never 0.
- x0 write and reset mid-operation: Rd_in=0, RegWrite=1 -> RegWrite_Out=1, fwd_en=0. Assert reset=0 while in state TWO -> all outputs 0 next cycle.
- SKID=0 variant: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle.
